// File: rtl/seu_arb_pkg.sv
// Shared types and helpers for the SEU event arbiter.
package seu_arb_pkg;

  // Output record holder state
  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } out_state_e;

  // Width of a channel index for n groups (at least one bit)
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seu_arb_rr_arbiter.sv
// Round-robin winner selection: first set request at or after ptr_i, wrapping.
module rr_arbiter
  import seu_arb_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned IW  = ch_idx_w(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  ptr_i,
  output logic           gnt_valid_o,
  output logic [IW-1:0]  gnt_idx_o,
  output logic [IW-1:0]  nxt_ptr_o
);

  // Scan from farthest offset down so the nearest request wins
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      int unsigned idx;
      idx = (int'(ptr_i) + k) % NCH;
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IW'(idx);
      end
    end
  end

  // Pointer moves one past the winner
  always_comb begin
    nxt_ptr_o = (int'(gnt_idx_o) == NCH - 1) ? '0 : gnt_idx_o + 1'b1;
  end

endmodule

// File: rtl/seu_event_arbiter.sv
// Collects per-group SEU flags, arbitrates them round-robin into a one-deep
// valid/ready event record, and keeps a saturating SEU cycle count plus
// sticky per-group lost-event flags.
// Optional feature macro: SEU_TIMESTAMP_EN adds a grant-time timestamp (ev_ts_o).
module seu_event_arbiter
  import seu_arb_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned CNTW = 8,
  parameter int unsigned TSW  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           err_i,
  input  logic                     cnt_clr_i,
  output logic                     ev_valid_o,
  input  logic                     ev_ready_i,
  output logic [ch_idx_w(NCH)-1:0] ev_ch_o,
`ifdef SEU_TIMESTAMP_EN
  output logic [TSW-1:0]           ev_ts_o,
`endif
  output logic [CNTW-1:0]          seu_count_o,
  output logic [NCH-1:0]           ovf_o,
  output logic                     busy_o
);

  localparam int unsigned IW = ch_idx_w(NCH);
  localparam logic [CNTW-1:0] CntMax = '1;

  out_state_e      state_q, state_d;
  logic [NCH-1:0]  pend_q, pend_d;
  logic [NCH-1:0]  ovf_q, ovf_d;
  logic [IW-1:0]   ch_q, ch_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            gnt_valid;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   nxt_ptr;
  logic            grant;
  logic            handshake;
  logic [NCH-1:0]  clr_mask;

  rr_arbiter #(
    .NCH (NCH),
    .IW  (IW)
  ) u_rr_arbiter (
    .req_i       (pend_q),
    .ptr_i       (rr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .nxt_ptr_o   (nxt_ptr)
  );

  assign ev_valid_o  = (state_q == StFull);
  assign handshake   = ev_valid_o && ev_ready_i;
  assign grant       = gnt_valid && ((state_q == StEmpty) || handshake);
  assign ev_ch_o     = ch_q;
  assign seu_count_o = cnt_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = (|pend_q) || ev_valid_o;

  // Next-state: output FSM, pending set/clear, pointer, counter, overflow
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    rr_d     = rr_q;
    clr_mask = '0;
    if (grant) begin
      state_d           = StFull;
      ch_d              = gnt_idx;
      rr_d              = nxt_ptr;
      clr_mask[gnt_idx] = 1'b1;
    end else if (handshake) begin
      state_d = StEmpty;
    end

    // A new error on the grant edge re-arms the bit, so nothing is dropped
    pend_d = (pend_q & ~clr_mask) | err_i;

    // Lost event: already pending and not being drained on this edge
    ovf_d = (cnt_clr_i ? '0 : ovf_q) | (err_i & pend_q & ~clr_mask);

    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = {{(CNTW-1){1'b0}}, |err_i};
    end else if ((|err_i) && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      pend_q  <= '0;
      ovf_q   <= '0;
      ch_q    <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SEU_TIMESTAMP_EN
  logic [TSW-1:0] ts_q;
  logic [TSW-1:0] ev_ts_q;

  // Free-running timestamp, captured into the record on each grant
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q    <= '0;
      ev_ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (grant) begin
        ev_ts_q <= ts_q;
      end
    end
  end

  assign ev_ts_o = ev_ts_q;
`else
  logic unused_tsw;
  assign unused_tsw = (TSW > 0);
`endif

endmodule
